// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store.
// Load/store wins ties unless it won the previous grant; unacknowledged transactions abort after TIMEOUT cycles.
module mem_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_valid_o,
   output logic [31:0] if_rdata_o,
   output logic        if_err_o,
   input  logic        ls_req_i,
   input  logic        ls_we_i,
   input  logic [31:0] ls_addr_i,
   input  logic [31:0] ls_wdata_i,
   input  logic [3:0]  ls_be_i,
   output logic        ls_valid_o,
   output logic [31:0] ls_rdata_o,
   output logic        ls_err_o,
   output logic [1:0]  mem_rw_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_be_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        busy_o
);

   typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_e;

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic        last_ls_q, last_ls_d;
   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  mem_rw_q, mem_rw_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic        if_valid_q, if_valid_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic        if_err_q, if_err_d;
   logic        ls_valid_q, ls_valid_d;
   logic [31:0] ls_rdata_q, ls_rdata_d;
   logic        ls_err_q, ls_err_d;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   always_comb begin
      state_d     = state_q;
      last_ls_d   = last_ls_q;
      cnt_d       = cnt_q;
      mem_rw_d    = mem_rw_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      if_valid_d  = 1'b0;
      if_rdata_d  = if_rdata_q;
      if_err_d    = if_err_q;
      ls_valid_d  = 1'b0;
      ls_rdata_d  = ls_rdata_q;
      ls_err_d    = ls_err_q;
      rsp_rdata   = 32'h0;
      rsp_err     = 1'b0;

      case (state_q)
         IDLE: begin
            // Fetch only wins a tie when load/store took the previous grant
            if (ls_req_i && (!if_req_i || !last_ls_q)) begin
               state_d     = DATA;
               last_ls_d   = 1'b1;
               cnt_d       = 16'h0;
               mem_rw_d    = ls_we_i ? 2'b10 : 2'b01;
               mem_addr_d  = ls_addr_i;
               mem_wdata_d = ls_wdata_i;
               mem_be_d    = ls_be_i;
            end else if (if_req_i) begin
               state_d     = FETCH;
               last_ls_d   = 1'b0;
               cnt_d       = 16'h0;
               mem_rw_d    = 2'b01;
               mem_addr_d  = if_addr_i;
               mem_wdata_d = 32'h0;
               mem_be_d    = 4'b1111;
            end
         end
         FETCH, DATA: begin
            if (mem_ack_i || cnt_q == CNT_LAST) begin
               state_d   = RESP;
               mem_rw_d  = 2'b00;
               rsp_err   = !mem_ack_i;
               rsp_rdata = (mem_ack_i && mem_rw_q == 2'b01) ? mem_rdata_i : 32'h0;
               if (state_q == FETCH) begin
                  if_valid_d = 1'b1;
                  if_rdata_d = rsp_rdata;
                  if_err_d   = rsp_err;
               end else begin
                  ls_valid_d = 1'b1;
                  ls_rdata_d = rsp_rdata;
                  ls_err_d   = rsp_err;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         last_ls_q   <= 1'b0;
         cnt_q       <= 16'h0;
         mem_rw_q    <= 2'b00;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         mem_be_q    <= 4'h0;
         if_valid_q  <= 1'b0;
         if_rdata_q  <= 32'h0;
         if_err_q    <= 1'b0;
         ls_valid_q  <= 1'b0;
         ls_rdata_q  <= 32'h0;
         ls_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_ls_q   <= last_ls_d;
         cnt_q       <= cnt_d;
         mem_rw_q    <= mem_rw_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         if_valid_q  <= if_valid_d;
         if_rdata_q  <= if_rdata_d;
         if_err_q    <= if_err_d;
         ls_valid_q  <= ls_valid_d;
         ls_rdata_q  <= ls_rdata_d;
         ls_err_q    <= ls_err_d;
      end
   end

   assign if_valid_o  = if_valid_q;
   assign if_rdata_o  = if_rdata_q;
   assign if_err_o    = if_err_q;
   assign ls_valid_o  = ls_valid_q;
   assign ls_rdata_o  = ls_rdata_q;
   assign ls_err_o    = ls_err_q;
   assign mem_rw_o    = mem_rw_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_be_o    = mem_be_q;
   assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected bus grants and responses,
// independent monitors pop and compare them whenever the DUT drives the bus or pulses a valid.
module tb_mem_arbiter;

   localparam int TB_TIMEOUT = 4;

   typedef struct {
      logic [1:0]  rw;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          dur;
   } bus_exp_t;

   typedef struct {
      bit          isLs;
      logic [31:0] rdata;
      logic        err;
   } rsp_exp_t;

   logic        clk;
   logic        rst;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_valid_o;
   logic [31:0] if_rdata_o;
   logic        if_err_o;
   logic        ls_req_i;
   logic        ls_we_i;
   logic [31:0] ls_addr_i;
   logic [31:0] ls_wdata_i;
   logic [3:0]  ls_be_i;
   logic        ls_valid_o;
   logic [31:0] ls_rdata_o;
   logic        ls_err_o;
   logic [1:0]  mem_rw_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic        busy_o;

   int compared;
   int mismatched;

   bus_exp_t busQ[$];
   rsp_exp_t rspQ[$];

   int          ackDelay;
   logic [31:0] rdVal;
   logic        spuriousAck;

   mem_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .if_req_i   (if_req_i),
      .if_addr_i  (if_addr_i),
      .if_valid_o (if_valid_o),
      .if_rdata_o (if_rdata_o),
      .if_err_o   (if_err_o),
      .ls_req_i   (ls_req_i),
      .ls_we_i    (ls_we_i),
      .ls_addr_i  (ls_addr_i),
      .ls_wdata_i (ls_wdata_i),
      .ls_be_i    (ls_be_i),
      .ls_valid_o (ls_valid_o),
      .ls_rdata_o (ls_rdata_o),
      .ls_err_o   (ls_err_o),
      .mem_rw_o   (mem_rw_o),
      .mem_addr_o (mem_addr_o),
      .mem_wdata_o(mem_wdata_o),
      .mem_be_o   (mem_be_o),
      .mem_ack_i  (mem_ack_i),
      .mem_rdata_i(mem_rdata_i),
      .busy_o     (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic boundExpired(input string name);
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: wait bound expired, got no event, expected one (t=%0t)", name, $time);
   endtask

   // Memory model: acks the ackDelay-th bus cycle of each transaction, optional ack while bus idle
   int   memIdx;
   logic memActive;
   always @(negedge clk) begin
      if (mem_rw_o != 2'b00) begin
         if (!memActive) begin
            memActive = 1'b1;
            memIdx    = 0;
         end else begin
            memIdx++;
         end
         mem_ack_i = (memIdx == ackDelay);
      end else begin
         memActive = 1'b0;
         mem_ack_i = spuriousAck;
      end
      mem_rdata_i = rdVal;
   end

   // Bus monitor: checks grant contents, drive length and stability
   logic     busActive;
   logic     busHaveExp;
   int       busCycles;
   logic     busStable;
   bus_exp_t busCur;
   logic [69:0] busSnap;
   always @(negedge clk) begin
      if (mem_rw_o != 2'b00) begin
         if (!busActive) begin
            busActive = 1'b1;
            busCycles = 1;
            busStable = 1'b1;
            busSnap   = {mem_rw_o, mem_addr_o, mem_wdata_o, mem_be_o};
            if (busQ.size() == 0) begin
               busHaveExp = 1'b0;
               checkOutput("unexpected_bus_grant", 32'(mem_rw_o), 32'h0);
            end else begin
               busHaveExp = 1'b1;
               busCur = busQ.pop_front();
               checkOutput("bus_rw", 32'(mem_rw_o), 32'(busCur.rw));
               checkOutput("bus_addr", mem_addr_o, busCur.addr);
               checkOutput("bus_wdata", mem_wdata_o, busCur.wdata);
               checkOutput("bus_be", 32'(mem_be_o), 32'(busCur.be));
            end
         end else begin
            busCycles++;
            if ({mem_rw_o, mem_addr_o, mem_wdata_o, mem_be_o} != busSnap) busStable = 1'b0;
         end
      end else if (busActive) begin
         busActive = 1'b0;
         if (busHaveExp) begin
            checkOutput("bus_cycles", 32'(busCycles), 32'(busCur.dur));
            checkOutput("bus_stable", 32'(busStable), 32'h1);
         end
      end
   end

   // Response monitor: every valid pulse must match the next queued response
   rsp_exp_t rspCur;
   always @(negedge clk) begin
      if (if_valid_o || ls_valid_o) begin
         if (rspQ.size() == 0) begin
            checkOutput("unexpected_valid", {30'h0, if_valid_o, ls_valid_o}, 32'h0);
         end else begin
            rspCur = rspQ.pop_front();
            checkOutput("valid_exclusive", 32'(if_valid_o & ls_valid_o), 32'h0);
            checkOutput("valid_source", 32'(ls_valid_o), 32'(rspCur.isLs));
            checkOutput("rsp_rdata", rspCur.isLs ? ls_rdata_o : if_rdata_o, rspCur.rdata);
            checkOutput("rsp_err", 32'(rspCur.isLs ? ls_err_o : if_err_o), 32'(rspCur.err));
         end
      end
   end

   task automatic pushExpect(input bit isLs, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be,
                             input int ack, input logic [31:0] rdata);
      bus_exp_t b;
      rsp_exp_t r;
      bit acked;
      acked   = (ack < TB_TIMEOUT);
      b.rw    = (isLs && we) ? 2'b10 : 2'b01;
      b.addr  = addr;
      b.wdata = isLs ? wdata : 32'h0;
      b.be    = isLs ? be : 4'b1111;
      b.dur   = acked ? ack + 1 : TB_TIMEOUT;
      r.isLs  = isLs;
      r.rdata = (acked && !(isLs && we)) ? rdata : 32'h0;
      r.err   = !acked;
      busQ.push_back(b);
      rspQ.push_back(r);
   endtask

   task automatic applyStimulus(input bit isLs, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                input int ack, input logic [31:0] rdata);
      bit seen;
      pushExpect(isLs, we, addr, wdata, be, ack, rdata);
      ackDelay = ack;
      rdVal    = rdata;
      if (isLs) begin
         ls_req_i   = 1'b1;
         ls_we_i    = we;
         ls_addr_i  = addr;
         ls_wdata_i = wdata;
         ls_be_i    = be;
      end else begin
         if_req_i  = 1'b1;
         if_addr_i = addr;
      end
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = isLs ? ls_valid_o : if_valid_o;
      end
      if (!seen) boundExpired("wait_valid");
      checkOutput("rw_idle_in_resp", 32'(mem_rw_o), 32'h0);
      checkOutput("busy_in_resp", 32'(busy_o), 32'h1);
      if_req_i = 1'b0;
      ls_req_i = 1'b0;
      @(negedge clk);
      checkOutput("busy_after_resp", 32'(busy_o), 32'h0);
      checkOutput("valid_one_cycle", {30'h0, if_valid_o, ls_valid_o}, 32'h0);
   endtask

   task automatic doReset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("rst_rw", 32'(mem_rw_o), 32'h0);
      checkOutput("rst_addr", mem_addr_o, 32'h0);
      checkOutput("rst_wdata", mem_wdata_o, 32'h0);
      checkOutput("rst_be", 32'(mem_be_o), 32'h0);
      checkOutput("rst_valids", {30'h0, if_valid_o, ls_valid_o}, 32'h0);
      checkOutput("rst_if_rdata", if_rdata_o, 32'h0);
      checkOutput("rst_ls_rdata", ls_rdata_o, 32'h0);
      checkOutput("rst_errs", {30'h0, if_err_o, ls_err_o}, 32'h0);
      checkOutput("rst_busy", 32'(busy_o), 32'h0);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL global_watchdog: simulation still running, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int pulses;
      compared    = 0;
      mismatched  = 0;
      rst         = 1'b1;
      if_req_i    = 1'b0;
      if_addr_i   = 32'h0;
      ls_req_i    = 1'b0;
      ls_we_i     = 1'b0;
      ls_addr_i   = 32'h0;
      ls_wdata_i  = 32'h0;
      ls_be_i     = 4'h0;
      mem_ack_i   = 1'b0;
      mem_rdata_i = 32'h0;
      ackDelay    = 1000;
      rdVal       = 32'h0;
      spuriousAck = 1'b0;
      memActive   = 1'b0;
      memIdx      = 0;
      busActive   = 1'b0;
      busHaveExp  = 1'b0;
      busCycles   = 0;
      busStable   = 1'b1;
      busSnap     = '0;

      $display("[TB] reset state");
      doReset();
      @(negedge clk);

      $display("[TB] single fetch");
      applyStimulus(1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 1, 32'h0000_0013);

      $display("[TB] store, ack on last allowed cycle");
      applyStimulus(1'b1, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 4'b0011, 3, 32'h1234_5678);

      $display("[TB] alternating grants from reset");
      doReset();
      @(negedge clk);
      ackDelay = 0;
      rdVal    = 32'hCAFE_0001;
      pushExpect(1'b1, 1'b0, 32'h0000_1000, 32'h1111_1111, 4'b0101, 0, 32'hCAFE_0001);
      pushExpect(1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 32'hCAFE_0001);
      pushExpect(1'b1, 1'b0, 32'h0000_1000, 32'h1111_1111, 4'b0101, 0, 32'hCAFE_0001);
      pushExpect(1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 32'hCAFE_0001);
      if_req_i   = 1'b1;
      if_addr_i  = 32'h0000_0040;
      ls_req_i   = 1'b1;
      ls_we_i    = 1'b0;
      ls_addr_i  = 32'h0000_1000;
      ls_wdata_i = 32'h1111_1111;
      ls_be_i    = 4'b0101;
      pulses = 0;
      for (int i = 0; i < 40 && pulses < 4; i++) begin
         @(negedge clk);
         if (if_valid_o || ls_valid_o) pulses++;
      end
      if (pulses < 4) boundExpired("wait_alternation");
      if_req_i = 1'b0;
      ls_req_i = 1'b0;
      @(negedge clk);

      $display("[TB] load timeout");
      applyStimulus(1'b1, 1'b0, 32'h2000_0010, 32'h0, 4'b1111, 1000, 32'hFFFF_FFFF);

      $display("[TB] reset during pending fetch");
      ackDelay  = 1000;
      rdVal     = 32'h0000_0777;
      busQ.push_back('{rw: 2'b01, addr: 32'h0000_0200, wdata: 32'h0, be: 4'b1111, dur: 2});
      if_req_i  = 1'b1;
      if_addr_i = 32'h0000_0200;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midrst_rw", 32'(mem_rw_o), 32'h0);
      checkOutput("midrst_busy", 32'(busy_o), 32'h0);
      checkOutput("midrst_valid", 32'(if_valid_o), 32'h0);
      pushExpect(1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 0, 32'h0000_0777);
      ackDelay = 0;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("regrant_busy", 32'(busy_o), 32'h1);
      checkOutput("regrant_rw", 32'(mem_rw_o), 32'h1);
      pulses = 0;
      for (int i = 0; i < 20 && pulses == 0; i++) begin
         if (if_valid_o) pulses = 1;
         else @(negedge clk);
      end
      if (pulses == 0) boundExpired("wait_regrant_valid");
      if_req_i = 1'b0;
      @(negedge clk);

      $display("[TB] spurious acks in idle and resp");
      spuriousAck = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("spurious_idle_busy", 32'(busy_o), 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0000_0300, 32'h0, 4'h0, 1, 32'h0BAD_F00D);
      repeat (3) @(negedge clk);
      checkOutput("spurious_after_busy", 32'(busy_o), 32'h0);
      spuriousAck = 1'b0;

      repeat (3) @(negedge clk);
      checkOutput("bus_queue_drained", 32'(busQ.size()), 32'h0);
      checkOutput("rsp_queue_drained", 32'(rspQ.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
